// File: rtl/data_ram_resp.sv
// data_ram_resp: data-memory responder for the RISC-V core load/store port.
// - Word-organised RAM of DEPTH x 32 bits mapped at BASE_ADDR.
// - Loads return one cycle after the request (rd_valid pulse).
// - After reset an init state machine clears every word before serving requests.
// - addr_err is a sticky flag; wr_count / rd_count are saturating access counters.
// Optional feature macro: DRAM_BYTE_EN
//   - adds the byte_en[3:0] port, which gives per-lane store enables.
module data_ram_resp #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          COUNT_W   = 16
) (
    input  logic               reloj,
    input  logic               reset,
    input  logic               ena_wr_sig,
    input  logic               ena_rd_sig,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        dataram_wr_sig,
`ifdef DRAM_BYTE_EN
    input  logic [3:0]         byte_en,
`endif
    output logic [31:0]        dout_ram,
    output logic               rd_valid,
    output logic               busy,
    output logic               addr_err,
    output logic [COUNT_W-1:0] wr_count,
    output logic [COUNT_W-1:0] rd_count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [31:0]     SPAN     = 32'(DEPTH * 4);
    localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        logic [COUNT_W-1:0] res;
        if (&v) begin
            res = v;
        end else begin
            res = v + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

`ifdef DRAM_BYTE_EN
    // Lane merge: enabled lanes take the new data, the others keep the old word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction
`endif

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_next_state;
    logic [AW-1:0]      r_clr_ptr;
    logic [31:0]        r_mem [DEPTH];

    logic [31:0]        r_dout;
    logic               r_rd_valid;
    logic               r_busy;
    logic               r_addr_err;
    logic [COUNT_W-1:0] r_wr_count;
    logic [COUNT_W-1:0] r_rd_count;

    // ------------------------------------------------------------------
    // Address decode (one shared address for both load and store)
    // ------------------------------------------------------------------
    logic [31:0]   w_off;
    logic          w_valid;
    logic [AW-1:0] w_idx;
    logic          w_ready;
    logic          w_st_ok;
    logic          w_ld_ok;
    logic          w_bad;
    logic [31:0]   w_old_word;
    logic [31:0]   w_wr_word;
    logic [31:0]   w_rd_word;
    logic          w_clr_we;
    logic          w_clr_last;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [31:0]   w_mem_wdata;

    assign w_off      = alu_result - BASE_ADDR;
    assign w_valid    = (alu_result[1:0] == 2'b00) && (w_off < SPAN);
    assign w_idx      = w_off[AW+1:2];
    // A request asserted together with reset is treated as never issued.
    assign w_ready    = (r_state == ST_READY) && !reset;
    assign w_st_ok    = w_ready && ena_wr_sig && w_valid;
    assign w_ld_ok    = w_ready && ena_rd_sig && w_valid;
    assign w_bad      = w_ready && (ena_wr_sig || ena_rd_sig) && !w_valid;
    assign w_old_word = r_mem[w_idx];
    assign w_clr_last = (r_clr_ptr == LAST_PTR);

`ifdef DRAM_BYTE_EN
    assign w_wr_word = merge_lanes(w_old_word, dataram_wr_sig, byte_en);
`else
    assign w_wr_word = dataram_wr_sig;
`endif

    // Load data select: write-first forwarding, zero for an invalid address.
    always_comb begin
        w_rd_word = 32'h0000_0000;
        if (!w_valid) begin
            w_rd_word = 32'h0000_0000;
        end else if (w_st_ok) begin
            w_rd_word = w_wr_word;
        end else begin
            w_rd_word = w_old_word;
        end
    end

    // ------------------------------------------------------------------
    // Init / ready state machine
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and clear-write enable.
    always_comb begin
        w_next_state = r_state;
        w_clr_we     = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_clr_we = !reset;
                if (w_clr_last) begin
                    w_next_state = ST_READY;
                end else begin
                    w_next_state = ST_INIT;
                end
            end
            ST_READY: begin
                w_next_state = ST_READY;
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    // Clear pointer walks every word once during init.
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_clr_ptr <= '0;
        end else if (w_clr_we) begin
            r_clr_ptr <= r_clr_ptr + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            r_clr_ptr <= r_clr_ptr;
        end
    end

    // Busy drops together with the final clear write.
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_busy <= 1'b1;
        end else if (w_clr_we && w_clr_last) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= r_busy;
        end
    end

    // ------------------------------------------------------------------
    // Memory array
    // ------------------------------------------------------------------

    // Single write port shared by the init clear and core stores.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = w_idx;
        w_mem_wdata = w_wr_word;
        if (w_clr_we) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_ptr;
            w_mem_wdata = 32'h0000_0000;
        end else if (w_st_ok) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = w_idx;
            w_mem_wdata = w_wr_word;
        end else begin
            w_mem_we    = 1'b0;
        end
    end

    // Memory write; contents are defined by the init clear, not by reset.
    always_ff @(posedge reloj) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Load response, error flag and counters
    // ------------------------------------------------------------------

    // Registered load data and its one-cycle valid pulse.
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_dout     <= 32'h0000_0000;
            r_rd_valid <= 1'b0;
        end else if (w_ready && ena_rd_sig) begin
            r_dout     <= w_rd_word;
            r_rd_valid <= 1'b1;
        end else begin
            r_dout     <= r_dout;
            r_rd_valid <= 1'b0;
        end
    end

    // Sticky address error.
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else if (w_bad) begin
            r_addr_err <= 1'b1;
        end else begin
            r_addr_err <= r_addr_err;
        end
    end

    // Saturating store counter.
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_wr_count <= '0;
        end else if (w_st_ok) begin
            r_wr_count <= sat_inc(r_wr_count);
        end else begin
            r_wr_count <= r_wr_count;
        end
    end

    // Saturating load counter.
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_rd_count <= '0;
        end else if (w_ld_ok) begin
            r_rd_count <= sat_inc(r_rd_count);
        end else begin
            r_rd_count <= r_rd_count;
        end
    end

    assign dout_ram = r_dout;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign addr_err = r_addr_err;
    assign wr_count = r_wr_count;
    assign rd_count = r_rd_count;

endmodule
